// File: rtl/regfile_pkg.sv
// Shared types and constants for regfile_multiport.
// Defining REGFILE_BYPASS_EN selects write-first forwarding on read/write address collisions.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int ADDR_W_DEF = $clog2(NREG_DEF);
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]   xlen_t;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: sampled zero flag, registered data with hold on stall,
// and the optional same-cycle write forwarding compare.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   array_word,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0] data_reg;
  logic            zero_reg;
  logic            addr_is_zero;
  logic            fwd_hit;

  assign addr_is_zero = (address == ADDR_W'(REG_ZERO));
  assign fwd_hit      = BYPASS_EN && write_enable && (write_address == address) && !addr_is_zero;

  // Registers only advance on an enabled RUN cycle; otherwise they hold (stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      zero_reg <= 1'b1;
    end else if (run && enable) begin
      zero_reg <= addr_is_zero;
      data_reg <= fwd_hit ? write_data : array_word;
    end
  end

  assign data = (!run || zero_reg) ? '0 : data_reg;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port integer register file with post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN: write-first forwarding on same-cycle read/write hits.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NREAD  = 2,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic [NREAD-1:0]        read_enable,
  input  logic [NREAD*ADDR_W-1:0] read_address,
  output logic [NREAD*XLEN-1:0]   read_data,
  input  logic                    write_enable,
  input  logic [ADDR_W-1:0]       write_address,
  input  logic [XLEN-1:0]         write_data
);

  logic [XLEN-1:0] rf [NREG];

  rf_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] clear_idx_reg, clear_idx_next;
  logic              run;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              ext_write;

  assign run   = (state_reg == RF_RUN);
  assign ready = run;

  // x0 is never written by the clear loop; reads of x0 are masked by the zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RF_CLEAR;
      clear_idx_reg <= ADDR_W'(1);
    end else begin
      state_reg     <= state_next;
      clear_idx_reg <= clear_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_idx_next = clear_idx_reg;
    if (state_reg == RF_CLEAR) begin
      clear_idx_next = clear_idx_reg + ADDR_W'(1);
      if (clear_idx_reg == ADDR_W'(NREG - 1)) begin
        state_next = RF_RUN;
      end
    end
  end

  assign ext_write = run && write_enable && (write_address != ADDR_W'(REG_ZERO));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clear_idx_reg;
    wr_data = '0;
    if (!run) begin
      wr_en = 1'b1;
    end else if (ext_write) begin
      wr_en   = 1'b1;
      wr_addr = write_address;
      wr_data = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_port
      logic [ADDR_W-1:0] port_addr;
      logic [XLEN-1:0]   port_word;

      assign port_addr = read_address[gi*ADDR_W +: ADDR_W];
      assign port_word = rf[port_addr];

      regfile_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
      ) u_port (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .enable        (read_enable[gi]),
        .address       (port_addr),
        .array_word    (port_word),
        .write_enable  (ext_write),
        .write_address (write_address),
        .write_data    (write_data),
        .data          (read_data[gi*XLEN +: XLEN])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_regfile_multiport;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NREAD  = 2;
  localparam int ADDR_W = 5;
  localparam int K_READY = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    ready;
  logic [NREAD-1:0]        read_enable;
  logic [NREAD*ADDR_W-1:0] read_address;
  logic [NREAD*XLEN-1:0]   read_data;
  logic                    write_enable;
  logic [ADDR_W-1:0]       write_address;
  logic [XLEN-1:0]         write_data;

  regfile_multiport #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
    .clk           (clk),
    .reset         (reset),
    .ready         (ready),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [31:0] act;
        act = (q[i].kind == K_READY) ? {31'b0, ready} : read_data[q[i].kind*XLEN +: XLEN];
        n_cmp++;
        if (q[i].cyc != cyc || act !== q[i].exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d kind=%0d got=%h want=%h", q[i].name, cyc, q[i].kind, act, q[i].exp);
        end else begin
          $display("ok   %s cyc=%0d kind=%0d val=%h", q[i].name, cyc, q[i].kind, act);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int ofs, input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + ofs; e.kind = kind; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic set_addr(input int p0, input int p1);
    read_address = {ADDR_W'(p1), ADDR_W'(p0)};
  endtask

  task automatic write_reg(input int a, input logic [31:0] v);
    write_enable = 1'b1; write_address = ADDR_W'(a); write_data = v;
    tick();
    write_enable = 1'b0;
  endtask

  // Release reset and check ready is low for NREG-1 cycles, then high.
  task automatic release_and_clear(input string tag);
    reset = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      expect_at(0, K_READY, 32'd0, {tag, "_ready_lo"});
      expect_at(0, 0, 32'd0, {tag, "_p0_zero"});
      tick();
    end
    expect_at(0, K_READY, 32'd1, {tag, "_ready_hi"});
  endtask

  logic [31:0] coll_exp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    coll_exp = 32'hA5A5A5A5;
`else
    coll_exp = 32'h00000011;
`endif
    reset = 1'b1; read_enable = '0; read_address = '0;
    write_enable = 1'b0; write_address = '0; write_data = '0;
    tick(); tick();
    expect_at(0, K_READY, 32'd0, "rst_ready");
    expect_at(0, 0, 32'd0, "rst_p0");
    expect_at(0, 1, 32'd0, "rst_p1");
    tick();

    // CLEAR with hostile traffic: write to x5 and reads must be ignored
    write_enable = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF;
    read_enable = 2'b11; set_addr(5, 5);
    release_and_clear("clr1");
    write_enable = 1'b0; read_enable = 2'b00;
    tick();

    read_enable = 2'b01; set_addr(5, 0);
    expect_at(1, 0, 32'd0, "x5_after_clear");
    tick(); read_enable = 2'b00;

    write_reg(3, 32'h12345678);
    read_enable = 2'b11; set_addr(3, 0);
    expect_at(1, 0, 32'h12345678, "rd_x3");
    expect_at(1, 1, 32'd0, "rd_x0_p1");
    tick(); read_enable = 2'b00;

    write_reg(7, 32'h00000077);
    write_reg(0, 32'hFFFFFFFF);
    read_enable = 2'b01; set_addr(0, 7);
    expect_at(1, 0, 32'd0, "x0_discard");
    expect_at(1, 1, 32'd0, "p1_stall_a");
    expect_at(2, 1, 32'd0, "p1_stall_b");
    tick(); tick(); read_enable = 2'b00;

    write_reg(9, 32'h00000011);
    write_enable = 1'b1; write_address = 5'd9; write_data = 32'hA5A5A5A5;
    read_enable = 2'b01; set_addr(9, 0);
    expect_at(1, 0, coll_exp, "rw_collision");
    tick();
    write_enable = 1'b0; read_enable = 2'b11; set_addr(9, 9);
    expect_at(1, 0, 32'hA5A5A5A5, "x9_after_p0");
    expect_at(1, 1, 32'hA5A5A5A5, "x9_after_p1");
    tick(); read_enable = 2'b00;

    write_reg(4, 32'h00000044);
    read_enable = 2'b01; set_addr(4, 9);
    expect_at(1, 0, 32'h00000044, "stall_pre");
    tick();
    read_enable = 2'b00; set_addr(3, 9);
    write_enable = 1'b1; write_address = 5'd4; write_data = 32'h00000055;
    expect_at(1, 0, 32'h00000044, "stall_hold_a");
    expect_at(2, 0, 32'h00000044, "stall_hold_b");
    tick(); write_enable = 1'b0;
    tick();
    read_enable = 2'b01; set_addr(4, 9);
    expect_at(1, 0, 32'h00000055, "stall_release");
    tick(); read_enable = 2'b00;
    tick();

    // Reset mid-CLEAR at index 10, then a full rerun
    reset = 1'b1;
    expect_at(0, 0, 32'd0, "arst_p0");
    expect_at(0, 1, 32'd0, "arst_p1");
    expect_at(0, K_READY, 32'd0, "arst_ready");
    tick();
    reset = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    expect_at(0, K_READY, 32'd0, "mid_rst_ready");
    tick();
    release_and_clear("clr2");
    tick();

    read_enable = 2'b11; set_addr(3, 4);
    expect_at(1, 0, 32'd0, "x3_recleared");
    expect_at(1, 1, 32'd0, "x4_recleared");
    tick(); read_enable = 2'b00;
    write_reg(12, 32'hCAFEF00D);
    read_enable = 2'b10; set_addr(0, 12);
    expect_at(1, 1, 32'hCAFEF00D, "post_rerun_wr");
    tick(); read_enable = 2'b00;
    tick(); tick();

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expectations got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=cyc%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
